// File: rtl/pitch_table_writer_if.sv
// Byte-stream input and pitch-RAM write port bundle for pitch_table_writer.
interface pitch_table_writer_if;
  logic        i_byte_valid;
  logic [7:0]  i_byte;
  logic        o_byte_ready;
  logic        o_ram_we;
  logic [7:0]  o_ram_addr;
  logic [15:0] o_ram_data;
  logic        o_done;
  logic [5:0]  o_pitch;
  logic        o_error;

  // Byte source and RAM/status consumer side
  modport master (
    output i_byte_valid, i_byte,
    input  o_byte_ready, o_ram_we, o_ram_addr, o_ram_data, o_done, o_pitch, o_error
  );

  // Table writer side
  modport slave (
    input  i_byte_valid, i_byte,
    output o_byte_ready, o_ram_we, o_ram_addr, o_ram_data, o_done, o_pitch, o_error
  );
endinterface

// File: rtl/pitch_table_writer.sv
// Pitch phase-delta table loader: parses a header byte (10pppppp) followed by a
// little-endian 32-bit delta, then writes it into the 256x16 pitch RAM as two
// words, low at {0,pitch,0} and high at {0,pitch,1}.
module pitch_table_writer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                 i_clk,
  input logic                 i_rst,
  pitch_table_writer_if.slave bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RX_B0    = 3'd1;
  localparam logic [2:0] RX_B1    = 3'd2;
  localparam logic [2:0] RX_B2    = 3'd3;
  localparam logic [2:0] RX_B3    = 3'd4;
  localparam logic [2:0] WRITE_LO = 3'd5;
  localparam logic [2:0] WRITE_HI = 3'd6;
  localparam logic [2:0] DONE     = 3'd7;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) + 1 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [5:0]       pitch;
  logic [31:0]      delta;
  logic             in_rx;
  logic             xfer;
  logic             hdr_ok;
  logic             timeout_hit;

  logic             ram_we;
  logic [7:0]       ram_addr;
  logic [15:0]      ram_data;
  logic             done;
  logic             error;
  logic [5:0]       pitch_out;

  assign in_rx  = (state == RX_B0) || (state == RX_B1) ||
                  (state == RX_B2) || (state == RX_B3);
  assign bus.o_byte_ready = !i_rst && ((state == IDLE) || in_rx);
  assign xfer   = bus.i_byte_valid && bus.o_byte_ready;
  assign hdr_ok = (bus.i_byte[7:6] == 2'b10);
  // A transfer in the same cycle always beats an expiring idle count
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && in_rx && !xfer && (cnt == CNT_LAST);

  // Frame payload capture (header pitch and delta bytes, little-endian)
  always_ff @(posedge i_clk) begin
    if (xfer) begin
      case (state)
        IDLE:    if (hdr_ok) pitch <= bus.i_byte[5:0];
        RX_B0:   delta[7:0]   <= bus.i_byte;
        RX_B1:   delta[15:8]  <= bus.i_byte;
        RX_B2:   delta[23:16] <= bus.i_byte;
        RX_B3:   delta[31:24] <= bus.i_byte;
        default: ;
      endcase
    end
  end

  // Frame sequencing, idle timeout and registered RAM/status outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      pitch_out <= '0;
    end else begin
      ram_we <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            if (hdr_ok) begin
              cnt   <= '0;
              state <= RX_B0;
            end else begin
              error <= 1'b1;
            end
          end
        end
        RX_B0, RX_B1, RX_B2: begin
          if (xfer) begin
            cnt   <= '0;
            state <= state + 3'd1;
          end else if (timeout_hit) begin
            state <= IDLE;
            error <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_B3: begin
          if (xfer) begin
            cnt      <= '0;
            state    <= WRITE_LO;
            ram_we   <= 1'b1;
            ram_addr <= {1'b0, pitch, 1'b0};
            ram_data <= delta[15:0];
          end else if (timeout_hit) begin
            state <= IDLE;
            error <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WRITE_LO: begin
          state    <= WRITE_HI;
          ram_we   <= 1'b1;
          ram_addr <= {1'b0, pitch, 1'b1};
          ram_data <= delta[31:16];
        end
        WRITE_HI: begin
          state     <= DONE;
          done      <= 1'b1;
          pitch_out <= pitch;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_ram_we   = ram_we;
  assign bus.o_ram_addr = ram_addr;
  assign bus.o_ram_data = ram_data;
  assign bus.o_done     = done;
  assign bus.o_error    = error;
  assign bus.o_pitch    = pitch_out;

endmodule

// File: tb/tb_pitch_table_writer.sv
// Scoreboard bench for pitch_table_writer: stimulus tasks push the expected RAM
// writes / done / error events, a negedge monitor pops and compares them.
module tb_pitch_table_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pitch_table_writer_if bus();

  pitch_table_writer #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  kind;   // 0 write, 1 done, 2 error
    logic [7:0]  addr;
    logic [15:0] data;   // write data, or pitch for done
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  logic [5:0] last_pitch;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every observed event must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && (bus.o_ram_we || bus.o_done || bus.o_error)) begin
      ev_t  e;
      logic [1:0] k;
      k = bus.o_ram_we ? 2'd0 : (bus.o_done ? 2'd1 : 2'd2);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event actual_kind=%0d addr=%0h data=%0h required=none",
                 k, bus.o_ram_addr, bus.o_ram_data);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind", {30'd0, k}, {30'd0, e.kind});
        chk("single_strobe", {29'd0, bus.o_ram_we, bus.o_done, bus.o_error},
            (e.kind == 2'd0) ? 32'd4 : (e.kind == 2'd1) ? 32'd2 : 32'd1);
        if (e.kind == 2'd0) begin
          chk("ram_addr", {24'd0, bus.o_ram_addr}, {24'd0, e.addr});
          chk("ram_data", {16'd0, bus.o_ram_data}, {16'd0, e.data});
          chk("ready_bp_write", {31'd0, bus.o_byte_ready}, 32'd0);
        end else if (e.kind == 2'd1) begin
          chk("done_pitch", {26'd0, bus.o_pitch}, {16'd0, e.data});
          chk("ready_bp_done", {31'd0, bus.o_byte_ready}, 32'd0);
        end
      end
    end
  end

  // Reference: entry for pitch p occupies words 2p (low half) and 2p+1 (high half)
  task automatic expect_frame(input logic [5:0] p, input logic [31:0] d);
    exp_q.push_back('{kind: 2'd0, addr: 8'(2 * p),     data: d[15:0]});
    exp_q.push_back('{kind: 2'd0, addr: 8'(2 * p + 1), data: d[31:16]});
    exp_q.push_back('{kind: 2'd1, addr: 8'd0,          data: 16'(p)});
    last_pitch = p;
  endtask

  task automatic expect_error();
    exp_q.push_back('{kind: 2'd2, addr: 8'd0, data: 16'd0});
  endtask

  // All driving happens at negedge; returns at the negedge after the transfer edge
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.i_byte_valid = 1'b1;
    bus.i_byte       = b;
    while (!bus.o_byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL ready_wait actual=stuck_low required=ready_within_100");
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.i_byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [5:0] p, input logic [31:0] d, input int maxgap);
    int g;
    expect_frame(p, d);
    send_byte({2'b10, p});
    for (int i = 0; i < 4; i++) begin
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      if (g > 0) idle(g);
      send_byte(d[8*i +: 8]);
    end
  endtask

  initial begin
    int n;
    logic [7:0] h;
    bus.i_byte_valid = 1'b0;
    bus.i_byte       = 8'h00;
    last_pitch       = 6'd0;

    // Reset held three cycles
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("ready_in_reset", {31'd0, bus.o_byte_ready}, 32'd0);
    end
    chk("reset_we",    {31'd0, bus.o_ram_we}, 32'd0);
    chk("reset_done",  {31'd0, bus.o_done},   32'd0);
    chk("reset_error", {31'd0, bus.o_error},  32'd0);
    chk("reset_addr",  {24'd0, bus.o_ram_addr}, 32'd0);
    chk("reset_data",  {16'd0, bus.o_ram_data}, 32'd0);
    chk("reset_pitch", {26'd0, bus.o_pitch},  32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, bus.o_byte_ready}, 32'd1);

    // Basic frame, back-to-back bytes
    send_frame(6'd5, 32'h12345678, 0);
    // Address extremes; the next header is held valid through WRITE/DONE
    send_frame(6'd63, 32'hFFFF0001, 0);
    send_frame(6'd0, 32'hCAFEBABE, 0);
    idle(3);

    // Bad header, then a good frame
    expect_error();
    send_byte(8'h45);
    send_frame(6'd2, 32'hA5A55A5A, 0);
    idle(2);

    // Stall of 16 cycles inside a frame aborts with an error
    expect_error();
    send_byte(8'h81);
    send_byte(8'h11);
    send_byte(8'h22);
    idle(16);
    idle(3);
    // Stall of 15 cycles still completes
    expect_frame(6'd1, 32'h44332211);
    send_byte(8'h81);
    send_byte(8'h11);
    send_byte(8'h22);
    idle(15);
    send_byte(8'h33);
    send_byte(8'h44);
    idle(2);

    // Reset mid-frame discards the partial entry
    send_byte(8'h90);
    send_byte(8'hAA);
    send_byte(8'hBB);
    bus.i_byte_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_frame(6'd16, 32'h0BADF00D, 0);

    // Randomized mix of good frames, bad headers and gaps
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(5, 0) == 0) begin
        h = 8'($urandom);
        while (h[7:6] == 2'b10) h = 8'($urandom);
        expect_error();
        send_byte(h);
      end else begin
        send_frame(6'($urandom), $urandom, int'($urandom_range(15, 0)));
      end
      n = int'($urandom_range(2, 0));
      if (n > 0) idle(n);
    end
    idle(1);

    // Drain the scoreboard
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    idle(5);
    chk("pitch_held", {26'd0, bus.o_pitch}, {26'd0, last_pitch});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
